// File: rtl/lsu_mem_initiator_pkg.sv
// Shared definitions for the load/store initiator: funct3 codes, error codes,
// FSM state encodings, byte-enable masks and the latched access record.
package lsu_mem_initiator_pkg;

    localparam int LSU_XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;

    localparam logic [3:0] BE_B_MASK  = 4'b0001;
    localparam logic [3:0] BE_H_LO    = 4'b0011;
    localparam logic [3:0] BE_H_HI    = 4'b1100;
    localparam logic [3:0] BE_W_MASK  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    typedef struct packed {
        logic       store;
        logic [2:0] f3;
        logic [1:0] lane;
        logic [4:0] rd;
    } lsu_acc_t;

    // Unsigned variants only exist for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_lane_align.sv
// Combinational lane steering: byte enables and replicated store data from the
// low address bits, plus load-lane extraction with sign/zero extension.
module lsu_lane_align
    import lsu_mem_initiator_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        be_o    = BE_W_MASK;
        wdata_o = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = BE_B_MASK << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = lane_i[1] ? BE_H_HI : BE_H_LO;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'b0, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'b0, half_sel};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator between execute and data memory.
// Build option LSU_MISALIGN_TRAP_EN: report misaligned accesses instead of aligning them down.
module lsu_mem_initiator
    import lsu_mem_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int XLEN        = LSU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_base,
    input  logic [11:0]     req_offset,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            done,
    output logic [4:0]      done_rd,
    output logic [XLEN-1:0] done_data,
    output logic [1:0]      err
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    lsu_state_e      state_q, state_d;
    lsu_acc_t        acc_q;
    logic [XLEN-1:0] addr_q, wdata_q, data_q;
    logic [3:0]      be_q;
    logic [1:0]      err_q;
    logic [CNT_W-1:0] cnt_q;

    logic            accept, mis, tmo_hit;
    logic [XLEN-1:0] addr_raw, addr_eff;
    logic [1:0]      acc_err;
    logic [1:0]      al_lane;
    logic [2:0]      al_f3;
    logic [3:0]      al_be;
    logic [31:0]     al_wdata, al_rdata;

    assign accept   = (state_q == ST_IDLE) && req_valid;
    assign addr_raw = req_base + {{(XLEN-12){req_offset[11]}}, req_offset};
    assign tmo_hit  = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        mis      = ((req_funct3[1:0] == 2'b01) && addr_raw[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (addr_raw[1:0] != 2'b00));
        addr_eff = addr_raw;
    end
`else
    // Misaligned H/W accesses are silently aligned down to their natural boundary.
    always_comb begin
        mis      = 1'b0;
        addr_eff = addr_raw;
        if (req_funct3[1:0] == 2'b10)
            addr_eff[1:0] = 2'b00;
        else if (req_funct3[1:0] == 2'b01)
            addr_eff[0] = 1'b0;
    end
`endif

    always_comb begin
        if (!f3_legal(req_funct3, req_store))
            acc_err = ERR_FUNCT3;
        else if (mis)
            acc_err = ERR_MISALIGN;
        else
            acc_err = ERR_OK;
    end

    // The aligner serves the incoming access in IDLE and the latched one afterwards.
    assign al_lane = (state_q == ST_IDLE) ? addr_eff[1:0] : acc_q.lane;
    assign al_f3   = (state_q == ST_IDLE) ? req_funct3    : acc_q.f3;

    lsu_lane_align u_align (
        .lane_i   (al_lane),
        .funct3_i (al_f3),
        .wdata_i  (req_wdata),
        .rdata_i  (mem_rdata),
        .be_o     (al_be),
        .wdata_o  (al_wdata),
        .rdata_o  (al_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (acc_err != ERR_OK) ? ST_RESP : ST_REQ;
            ST_REQ: begin
                if (mem_ready)
                    state_d = acc_q.store ? ST_RESP : ST_WAIT;
                else if (tmo_hit)
                    state_d = ST_RESP;
            end
            ST_WAIT: if (mem_rvalid || tmo_hit) state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            be_q    <= '0;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    acc_q.store <= req_store;
                    acc_q.f3    <= req_funct3;
                    acc_q.lane  <= addr_eff[1:0];
                    acc_q.rd    <= req_store ? 5'd0 : req_rd;
                    addr_q      <= {addr_eff[XLEN-1:2], 2'b00};
                    wdata_q     <= req_store ? al_wdata : '0;
                    be_q        <= al_be;
                    data_q      <= '0;
                    err_q       <= acc_err;
                    cnt_q       <= '0;
                end
                ST_REQ: begin
                    if (mem_ready)
                        cnt_q <= '0;
                    else if (tmo_hit)
                        err_q <= ERR_TIMEOUT;
                    else
                        cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_WAIT: begin
                    if (mem_rvalid)
                        data_q <= al_rdata;
                    else if (tmo_hit)
                        err_q <= ERR_TIMEOUT;
                    else
                        cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        mem_valid = (state_q == ST_REQ);
        mem_we    = (state_q == ST_REQ) && acc_q.store;
        mem_be    = (state_q == ST_REQ) ? be_q : 4'b0000;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        done      = (state_q == ST_RESP);
        err       = done ? err_q : ERR_OK;
        done_rd   = (done && err_q == ERR_OK) ? acc_q.rd : 5'd0;
        done_data = (done && err_q == ERR_OK) ? data_q : '0;
    end

endmodule
